// File: rtl/pipe_reg_skid_pkg.sv
// Shared definitions for the pipeline skid stage: state encoding and the
// default widths of the EX/MM1 payload and control bundles.
package pipe_reg_skid_pkg;

    // Occupancy-coded stage state; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // EX/MM1 bundle widths: payload survives a flush, control does not.
    localparam int EX_DATA_W   = 96;
    localparam int EX_CTRL_W   = 16;
    localparam int STALL_CNT_W = 16;

    // Number of entries held in a given state.
    function automatic logic [1:0] occ_of(state_t s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_reg_skid_if.sv
// Upstream and downstream handshake bundle of the pipeline skid stage.
//
// Handshake: a side transfers an entry on a rising clk edge where its valid
// and ready are both 1. A producer holds valid and its payload stable until
// the transfer happens; ready may change freely and never depends on valid
// of the same side.
interface pipe_reg_skid_if
    import pipe_reg_skid_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int CTRL_W = EX_CTRL_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    // Environment side: offers upstream entries, accepts downstream ones.
    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    // Stage side.
    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

endinterface

// File: rtl/pipe_reg_skid_entry_reg.sv
// One pipeline entry: payload register with load enable and a control
// register that can be cleared independently (flush / bubble insertion).
module pipe_entry_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Payload is only ever loaded; a clear leaves stale data behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    // Control is zeroed on clear, which wins over a simultaneous load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl <= '0;
        end else if (clear) begin
            ctrl <= '0;
        end else if (load) begin
            ctrl <= load_ctrl;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline register between two stages. SKID=1 gives a two-entry skid
// buffer whose in_ready comes only from flops; SKID=0 is a single register
// with a combinational ready pass-through. flush kills everything held and
// the entry offered in the same cycle.
module pipe_reg_skid
    import pipe_reg_skid_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int CTRL_W = EX_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = STALL_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_reg_skid_if.slave      bus,
    output logic [1:0]          occupancy,
    output logic [CNT_W-1:0]    stall_cnt,
    output state_t              state
);

    state_t            state_q;
    state_t            state_d;
    logic              run_q;
    logic              accept;
    logic              drain;
    logic              head_load;
    logic              head_clear;
    logic              head_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] head_src_data;
    logic [CTRL_W-1:0] head_src_ctrl;

    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_data  = head_data;
    assign bus.out_ctrl  = head_ctrl;
    assign occupancy     = occ_of(state_q);
    assign state         = state_q;

    // run_q keeps in_ready low during reset and until the first edge after it.
    generate
        if (SKID != 0) begin : g_ready_reg
            assign bus.in_ready = run_q && (state_q != ST_FULL);
        end else begin : g_ready_comb
            assign bus.in_ready = run_q && (!bus.out_valid || bus.out_ready);
        end
    endgenerate

    assign accept = bus.in_valid && bus.in_ready;
    assign drain  = bus.out_valid && bus.out_ready;

    // Marks the stage live from the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and entry-register controls; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_d    = ST_EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        head_load = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        // Head leaves and the new entry takes its place.
                        head_load = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end else if (drain) begin
                        head_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: begin
                    state_d    = ST_EMPTY;
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    // The head refills from the skid entry when one is waiting behind it.
    always_comb begin
        head_src_data = bus.in_data;
        head_src_ctrl = bus.in_ctrl;
        if (head_from_skid) begin
            head_src_data = skid_data;
            head_src_ctrl = skid_ctrl;
        end
    end

    pipe_entry_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_head (
        .clk       (clk),
        .rst       (rst),
        .load      (head_load),
        .clear     (head_clear),
        .load_data (head_src_data),
        .load_ctrl (head_src_ctrl),
        .data      (head_data),
        .ctrl      (head_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry_reg #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_skid (
                .clk       (clk),
                .rst       (rst),
                .load      (skid_load),
                .clear     (skid_clear),
                .load_data (bus.in_data),
                .load_ctrl (bus.in_ctrl),
                .data      (skid_data),
                .ctrl      (skid_ctrl)
            );
        end else begin : g_no_skid
            assign skid_data = '0;
            assign skid_ctrl = '0;
        end
    endgenerate

    // Saturating count of cycles where the head is offered but not taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.out_valid && !bus.out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: a SKID=1 instance (4-bit stall counter) and a
// SKID=0 instance, both checked every cycle against a queue-based model,
// plus a vector table and directed sequences for flush, reset and stalls.
module tb_pipe_reg_skid;
    import pipe_reg_skid_pkg::*;

    localparam int DW    = 96;
    localparam int CW    = 16;
    localparam int EW    = DW + CW;
    localparam int S_MAX = 15;
    localparam int R_MAX = 65535;

    logic        clk;
    logic        rst;
    logic        flush_s;
    logic        flush_r;
    logic [1:0]  occ_s;
    logic [1:0]  occ_r;
    logic [3:0]  stall_s;
    logic [15:0] stall_r;
    state_t      state_s;
    state_t      state_r;

    pipe_reg_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus_s ();
    pipe_reg_skid_if #(.DATA_W(DW), .CTRL_W(CW)) bus_r ();

    pipe_reg_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_s),
        .bus       (bus_s),
        .occupancy (occ_s),
        .stall_cnt (stall_s),
        .state     (state_s)
    );

    pipe_reg_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_r),
        .bus       (bus_r),
        .occupancy (occ_r),
        .stall_cnt (stall_r),
        .state     (state_r)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard / reference model: entries held, oldest first ({ctrl,data}).
    logic [EW-1:0] exp_q_s[$];
    logic [EW-1:0] exp_q_r[$];
    bit            run_s = 1'b0;
    bit            run_r = 1'b0;
    int            stl_s = 0;
    int            stl_r = 0;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          fl;
        logic          e_ir;
        logic          e_ov;
        logic [CW-1:0] e_oc;
        logic [DW-1:0] e_od;
        logic [1:0]    e_occ;
    } vec_t;

    vec_t vt[10];

    function automatic bit mdl_ready_s();
        return run_s && (exp_q_s.size() < 2);
    endfunction

    function automatic bit mdl_ready_r();
        return run_r && ((exp_q_r.size() == 0) || (bus_r.out_ready == 1'b1));
    endfunction

    task automatic mdl_reset();
        exp_q_s.delete();
        exp_q_r.delete();
        run_s = 1'b0;
        run_r = 1'b0;
        stl_s = 0;
        stl_r = 0;
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic mdl_edge();
        bit acc_s;
        bit drn_s;
        bit acc_r;
        bit drn_r;
        if (rst) begin
            mdl_reset();
        end else begin
            acc_s = bus_s.in_valid && mdl_ready_s();
            drn_s = (exp_q_s.size() != 0) && bus_s.out_ready;
            acc_r = bus_r.in_valid && mdl_ready_r();
            drn_r = (exp_q_r.size() != 0) && bus_r.out_ready;
            if ((exp_q_s.size() != 0) && !bus_s.out_ready && (stl_s < S_MAX)) stl_s++;
            if ((exp_q_r.size() != 0) && !bus_r.out_ready && (stl_r < R_MAX)) stl_r++;
            if (flush_s) begin
                exp_q_s.delete();
            end else begin
                if (drn_s) void'(exp_q_s.pop_front());
                if (acc_s) exp_q_s.push_back({bus_s.in_ctrl, bus_s.in_data});
            end
            if (flush_r) begin
                exp_q_r.delete();
            end else begin
                if (drn_r) void'(exp_q_r.pop_front());
                if (acc_r) exp_q_r.push_back({bus_r.in_ctrl, bus_r.in_data});
            end
            run_s = 1'b1;
            run_r = 1'b1;
        end
    endtask

    task automatic tick();
        mdl_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Driver tasks.
    task automatic drive_s(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                           input logic ordy, input logic fl);
        bus_s.in_valid  = iv;
        bus_s.in_data   = d;
        bus_s.in_ctrl   = c;
        bus_s.out_ready = ordy;
        flush_s         = fl;
    endtask

    task automatic drive_r(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                           input logic ordy, input logic fl);
        bus_r.in_valid  = iv;
        bus_r.in_data   = d;
        bus_r.in_ctrl   = c;
        bus_r.out_ready = ordy;
        flush_r         = fl;
    endtask

    task automatic drive_both(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                              input logic ordy, input logic fl);
        drive_s(iv, d, c, ordy, fl);
        drive_r(iv, d, c, ordy, fl);
    endtask

    // Compare both instances against the model.
    task automatic check_models();
        logic [EW-1:0] hs;
        logic [EW-1:0] hr;
        hs = (exp_q_s.size() != 0) ? exp_q_s[0] : '0;
        hr = (exp_q_r.size() != 0) ? exp_q_r[0] : '0;
        chk("s_in_ready", bus_s.in_ready, mdl_ready_s());
        chk("s_out_valid", bus_s.out_valid, exp_q_s.size() != 0);
        chk("s_out_ctrl", bus_s.out_ctrl, hs[EW-1:DW]);
        if (exp_q_s.size() != 0) chk("s_out_data", bus_s.out_data, hs[DW-1:0]);
        chk("s_occupancy", occ_s, exp_q_s.size());
        chk("s_state", state_s, exp_q_s.size());
        chk("s_stall_cnt", stall_s, stl_s);
        chk("r_in_ready", bus_r.in_ready, mdl_ready_r());
        chk("r_out_valid", bus_r.out_valid, exp_q_r.size() != 0);
        chk("r_out_ctrl", bus_r.out_ctrl, hr[EW-1:DW]);
        if (exp_q_r.size() != 0) chk("r_out_data", bus_r.out_data, hr[DW-1:0]);
        chk("r_occupancy", occ_r, exp_q_r.size());
        chk("r_state", state_r, exp_q_r.size());
        chk("r_stall_cnt", stall_r, stl_r);
    endtask

    initial begin
        // Vector table for the SKID=1 instance: inputs for the cycle and the
        // outputs expected in that same cycle (before the consuming edge).
        vt[0] = '{1'b1, 96'h123, 16'h00A5, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0,    96'h0,   2'd0};
        vt[1] = '{1'b0, 96'h0,   16'h0,    1'b1, 1'b0, 1'b1, 1'b1, 16'h00A5, 96'h123, 2'd1};
        vt[2] = '{1'b0, 96'h0,   16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 16'h0,    96'h0,   2'd0};
        vt[3] = '{1'b1, 96'hA1,  16'h000A, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0,    96'h0,   2'd0};
        vt[4] = '{1'b1, 96'hB2,  16'h000B, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000A, 96'hA1,  2'd1};
        vt[5] = '{1'b1, 96'hC3,  16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000A, 96'hA1,  2'd2};
        vt[6] = '{1'b1, 96'hC3,  16'h000C, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000A, 96'hA1,  2'd2};
        vt[7] = '{1'b1, 96'hC3,  16'h000C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h000B, 96'hB2,  2'd1};
        vt[8] = '{1'b0, 96'h0,   16'h0,    1'b1, 1'b0, 1'b1, 1'b1, 16'h000C, 96'hC3,  2'd1};
        vt[9] = '{1'b0, 96'h0,   16'h0,    1'b1, 1'b0, 1'b1, 1'b0, 16'h0,    96'h0,   2'd0};

        // Reset.
        rst = 1'b1;
        drive_both(1'b0, '0, '0, 1'b0, 1'b0);
        mdl_reset();
        repeat (3) tick();
        chk("rst_in_ready", bus_s.in_ready, 1'b0);
        chk("rst_out_valid", bus_s.out_valid, 1'b0);
        chk("rst_out_ctrl", bus_s.out_ctrl, 16'h0);
        chk("rst_out_data", bus_s.out_data, 96'h0);
        chk("rst_occupancy", occ_s, 2'd0);
        chk("rst_stall_cnt", stall_s, 4'd0);
        chk("rst_state", state_s, ST_EMPTY);
        chk("rst_r_in_ready", bus_r.in_ready, 1'b0);
        check_models();
        rst = 1'b0;
        #1;
        check_models();
        tick();
        chk("release_in_ready", bus_s.in_ready, 1'b1);
        chk("release_r_in_ready", bus_r.in_ready, 1'b1);

        // Table: single pass-through entry, then back-to-back fill and drain.
        for (int i = 0; i < 10; i++) begin
            drive_both(vt[i].iv, vt[i].d, vt[i].c, vt[i].ordy, vt[i].fl);
            #1;
            chk($sformatf("vec%0d_in_ready", i), bus_s.in_ready, vt[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), bus_s.out_valid, vt[i].e_ov);
            chk($sformatf("vec%0d_out_ctrl", i), bus_s.out_ctrl, vt[i].e_oc);
            if (vt[i].e_ov) chk($sformatf("vec%0d_out_data", i), bus_s.out_data, vt[i].e_od);
            chk($sformatf("vec%0d_occupancy", i), occ_s, vt[i].e_occ);
            check_models();
            tick();
        end

        // Flush while FULL with a new offer: nothing survives or emerges.
        drive_both(1'b1, 96'hD1, 16'h00D1, 1'b0, 1'b0); #1; check_models(); tick();
        drive_both(1'b1, 96'hD2, 16'h00D2, 1'b0, 1'b0); #1; check_models(); tick();
        drive_both(1'b1, 96'hD3, 16'h00D3, 1'b0, 1'b1); #1;
        chk("flush_full_before", occ_s, 2'd2);
        check_models();
        tick();
        drive_both(1'b0, '0, '0, 1'b1, 1'b0); #1;
        chk("flush_occupancy", occ_s, 2'd0);
        chk("flush_out_valid", bus_s.out_valid, 1'b0);
        chk("flush_out_ctrl", bus_s.out_ctrl, 16'h0);
        check_models();
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_both(1'b0, '0, '0, 1'b1, 1'b0); #1;
            chk("flush_no_emit", bus_s.out_valid, 1'b0);
            check_models();
            tick();
        end

        // Asynchronous reset in the middle of a cycle while FULL.
        drive_both(1'b1, 96'hE1, 16'h00E1, 1'b0, 1'b0); #1; check_models(); tick();
        drive_both(1'b1, 96'hE2, 16'h00E2, 1'b0, 1'b0); #1; check_models(); tick();
        drive_both(1'b0, '0, '0, 1'b0, 1'b0); #1;
        chk("arst_full_before", occ_s, 2'd2);
        #1;
        rst = 1'b1;
        mdl_reset();
        #1;
        chk("arst_in_ready", bus_s.in_ready, 1'b0);
        chk("arst_out_valid", bus_s.out_valid, 1'b0);
        chk("arst_out_ctrl", bus_s.out_ctrl, 16'h0);
        chk("arst_out_data", bus_s.out_data, 96'h0);
        chk("arst_occupancy", occ_s, 2'd0);
        chk("arst_stall_cnt", stall_s, 4'd0);
        check_models();
        repeat (2) tick();
        drive_both(1'b0, '0, '0, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check_models();
        tick();
        chk("arst_release_in_ready", bus_s.in_ready, 1'b1);
        chk("arst_release_no_emit", bus_s.out_valid, 1'b0);
        check_models();

        // Stall counter saturation on the 4-bit instance.
        drive_both(1'b1, 96'hF1, 16'h00F1, 1'b0, 1'b0); #1; check_models(); tick();
        for (int i = 0; i < 22; i++) begin
            drive_both(1'b0, '0, '0, 1'b0, 1'b0); #1;
            check_models();
            tick();
        end
        chk("stall_saturated", stall_s, 4'hF);
        drive_both(1'b0, '0, '0, 1'b0, 1'b0); #1; tick();
        chk("stall_stays", stall_s, 4'hF);
        drive_both(1'b0, '0, '0, 1'b1, 1'b1); #1; check_models(); tick();

        // SKID=0: ready passes through when the head is taken this cycle.
        drive_s(1'b0, '0, '0, 1'b1, 1'b0);
        drive_r(1'b1, 96'h5E, 16'h005E, 1'b1, 1'b0); #1; check_models(); tick();
        drive_r(1'b1, 96'h5F, 16'h005F, 1'b1, 1'b0); #1;
        chk("r_pass_in_ready", bus_r.in_ready, 1'b1);
        chk("r_pass_head", bus_r.out_data, 96'h5E);
        check_models();
        tick();
        drive_r(1'b0, '0, '0, 1'b0, 1'b0); #1;
        chk("r_next_valid", bus_r.out_valid, 1'b1);
        chk("r_next_head", bus_r.out_data, 96'h5F);
        chk("r_blocked_in_ready", bus_r.in_ready, 1'b0);
        check_models();
        tick();

        // Randomised traffic on both instances against the model.
        for (int i = 0; i < 800; i++) begin
            drive_s($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom}, 16'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            drive_r($urandom_range(0, 3) != 0, {$urandom, $urandom, $urandom}, 16'($urandom),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            #1;
            check_models();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 Parameter DATA_W, default 96, payload bits held across a flush (operands, addresses, write data).
REQ-002 Parameter CTRL_W, default 16, control bits zeroed on flush and on bubble (op, op_type, re/we, reg write enable).
REQ-003 Parameter SKID, default 1; 1 = two-entry skid stage, 0 = single-entry register.
REQ-004 Parameter CNT_W, default 16, stall counter width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 flush  input  1  kill all held and incoming entries.
REQ-008 in_valid  input  1  upstream entry offered.
REQ-009 in_ready  output  1  stage accepts an entry this cycle.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 in_ctrl  input  CTRL_W  upstream control.
REQ-012 out_valid  output  1  head entry presented downstream.
REQ-013 out_ready  input  1  downstream accepts head.
REQ-014 out_data  output  DATA_W  head payload.
REQ-015 out_ctrl  output  CTRL_W  head control, zero when out_valid=0.
REQ-016 occupancy  output  2  entries held (0..2; max 1 when SKID=0).
REQ-017 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-018 A transfer occurs on a rising edge where valid and ready are both 1 on that side.
REQ-019 Accepted entry appears at out_* on the next cycle (latency 1); entries leave in acceptance order.
REQ-020 SKID=1: in_ready = (occupancy < 2), driven only from registers; there is no combinational path from out_ready to in_ready.
REQ-021 SKID=0: in_ready = !out_valid || out_ready (combinational).
REQ-022 SKID=1 states EMPTY/ONE/FULL: EMPTY->ONE on accept; ONE->FULL on accept without drain; ONE->EMPTY on drain without accept; ONE holds on accept+drain; FULL->ONE on drain; FULL holds otherwise.
REQ-023 Simultaneous accept and drain in ONE replaces the head with the new entry in the same edge.
REQ-024 flush has priority: next cycle occupancy=0, out_valid=0, out_ctrl=0; the input offered in the flush cycle is discarded; in_ready is not gated by flush.
REQ-025 An out handshake in the flush cycle counts as delivered; downstream handles its own flush.
REQ-026 out_data and skid payload registers are not cleared by flush or bubble (don't-care when out_valid=0).
REQ-027 stall_cnt increments by 1 per stalled cycle, saturates at all-ones, is cleared only by rst.
REQ-028 No input combination may drop or duplicate an entry except via flush.

Reset
REQ-029 While rst=1: in_ready=0, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0, state EMPTY.
REQ-030 First edge after rst deasserts: in_ready=1; rst mid-transfer discards all entries without emitting one.

Structure
REQ-031 Shared package holds the state encoding (EMPTY=0, ONE=1, FULL=2) and default widths of the EX/MM1 payload and control bundles.
REQ-032 One sub-module, pipe_entry_reg (data+ctrl register with load enable and ctrl clear), instantiated twice for SKID=1 and once for SKID=0.

Verification
REQ-033 SKID=1, out_ready=1, in_valid pulse with in_ctrl=0x00A5, in_data=0x123 -> out_valid=1 one cycle later with same values, occupancy returns 0.
REQ-034 SKID=1, out_ready=0, three back-to-back offers A,B,C -> A,B accepted, in_ready=0 on C, occupancy=2; out_ready=1 -> A then B then C in order.
REQ-035 FULL, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; no entry ever emitted afterwards.
REQ-036 CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt=15, stays 15.
REQ-037 SKID=0, out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 same cycle, new entry presented next cycle.
REQ-038 rst asserted asynchronously mid-cycle while FULL -> outputs zero immediately, in_ready=1 on first edge after release.
